ps2_transmitter: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.

---
 rtl/ps2_transmitter.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 command transmitter: clock inhibit, request-to-send, an odd-parity
// frame clocked out by the device, ACK/NACK sampling and a per-edge watchdog.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       sys_clk,
    input  logic       sync_rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic [1:0] tx_status,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [PH_W-1:0] SET_LAST = PH_W'(SETUP_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_ACK     = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_START, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t            state, state_d;
    logic [PH_W-1:0]   phase_cnt, phase_d;
    logic [WD_W-1:0]   wd_cnt, wd_d;
    logic [3:0]        bit_cnt, bit_d;
    logic [7:0]        tx_byte, byte_d;
    logic              parity, parity_d;
    logic              nack, nack_d;
    logic              clk_oe_d, data_oe_d, done_d;
    logic [1:0]        status_d;

    logic clk_q1, clk_q2, clk_q3, data_q1, data_q2;
    logic clk_fell, wd_expired;

    // Synchronisers preset high so an idle bus never looks like a falling edge out of reset.
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            clk_q1  <= 1'b1;
            clk_q2  <= 1'b1;
            clk_q3  <= 1'b1;
            data_q1 <= 1'b1;
            data_q2 <= 1'b1;
        end else begin
            clk_q1  <= ps2_clk_in;
            clk_q2  <= clk_q1;
            clk_q3  <= clk_q2;
            data_q1 <= ps2_data_in;
            data_q2 <= data_q1;
        end
    end

    assign clk_fell   = clk_q3 & ~clk_q2;
    assign wd_expired = (wd_cnt == WD_LAST);

    // Handshake: a byte is taken on any cycle where tx_valid and tx_ready are both high;
    // tx_valid raised while busy is dropped, never held over.
    always_comb begin
        state_d   = state;
        phase_d   = phase_cnt;
        wd_d      = wd_cnt;
        bit_d     = bit_cnt;
        byte_d    = tx_byte;
        parity_d  = parity;
        nack_d    = nack;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        status_d  = tx_status;
        case (state)
            S_IDLE: begin
                if (tx_valid && tx_ready) begin
                    byte_d   = tx_data;
                    parity_d = ~^tx_data;
                    phase_d  = '0;
                    clk_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                if (phase_cnt == INH_LAST) begin
                    phase_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    phase_d = phase_cnt + 1'b1;
                end
            end
            S_REQ: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b1;
                if (phase_cnt == SET_LAST) begin
                    phase_d  = '0;
                    bit_d    = '0;
                    wd_d     = '0;
                    clk_oe_d = 1'b0;
                    state_d  = S_START;
                end else begin
                    phase_d = phase_cnt + 1'b1;
                end
            end
            S_START: begin
                data_oe_d = ps2_data_oe;
                // An edge in the expiry cycle wins over the watchdog.
                if (clk_fell) begin
                    bit_d = bit_cnt + 1'b1;
                    wd_d  = '0;
                    if (bit_cnt < 4'd8) begin
                        data_oe_d = ~tx_byte[bit_cnt[2:0]];
                    end else if (bit_cnt == 4'd8) begin
                        data_oe_d = ~parity;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (wd_expired) begin
                    data_oe_d = 1'b0;
                    done_d    = 1'b1;
                    status_d  = ST_TIMEOUT;
                    state_d   = S_IDLE;
                end else begin
                    wd_d = wd_cnt + 1'b1;
                end
            end
            S_ACK: begin
                if (clk_fell) begin
                    bit_d   = bit_cnt + 1'b1;
                    wd_d    = '0;
                    nack_d  = data_q2;
                    state_d = S_WAIT_IDLE;
                end else if (wd_expired) begin
                    done_d   = 1'b1;
                    status_d = ST_TIMEOUT;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_q2 && data_q2) begin
                    done_d   = 1'b1;
                    status_d = nack ? ST_NACK : ST_ACK;
                    state_d  = S_IDLE;
                end else if (wd_expired) begin
                    done_d   = 1'b1;
                    status_d = ST_TIMEOUT;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_cnt + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            state       <= S_IDLE;
            phase_cnt   <= '0;
            wd_cnt      <= '0;
            bit_cnt     <= '0;
            tx_byte     <= '0;
            parity      <= 1'b0;
            nack        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_status   <= ST_ACK;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            phase_cnt   <= phase_d;
            wd_cnt      <= wd_d;
            bit_cnt     <= bit_d;
            tx_byte     <= byte_d;
            parity      <= parity_d;
            nack        <= nack_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_done     <= done_d;
            tx_status   <= status_d;
            tx_ready    <= (state_d == S_IDLE);
            busy        <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: transaction-level model of the host timeline plus an
// open-drain PS/2 device that clocks the frame, samples it, and ACKs/NACKs/stalls.
module tb_ps2_transmitter;
  localparam int INH  = 20;
  localparam int SET  = 4;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       sys_clk = 1'b0;
  logic       sync_rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done;
  logic [1:0] tx_status;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES(SET),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk),
    .sync_rst_n(sync_rst_n),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .busy(busy),
    .tx_done(tx_done),
    .tx_status(tx_status),
    .ps2_clk_in(ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // clock / reset / cycle count
  always #5 sys_clk = ~sys_clk;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // transaction model: accept cycle, predicted completion cycle and status
  logic       chk_en = 1'b0;
  logic       m_active = 1'b0;
  int         m_acc = 0;
  int         m_done = -1;
  logic [1:0] m_status_next = 2'b00;
  logic [1:0] m_status_vis = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_done = -1;
    m_status_next = 2'b00;
    m_status_vis = 2'b00;
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge sys_clk) begin : compare
    int   ph;
    logic exp_done, exp_busy, exp_clk;
    #1;
    if (chk_en) begin
      ph = cyc - m_acc;
      exp_done = m_active && (cyc == m_done);
      if (exp_done) m_status_vis = m_status_next;
      exp_busy = m_active && !exp_done;
      exp_clk = exp_busy && (ph < INH + SET);
      chk("tx_done", tx_done, exp_done);
      chk("busy", busy, exp_busy);
      chk("tx_ready", tx_ready, !exp_busy);
      chk("tx_status", tx_status, m_status_vis);
      chk("clk_oe", ps2_clk_oe, exp_clk);
      if (!exp_busy) chk("data_oe_idle", ps2_data_oe, 1'b0);
      else if (ph < INH + SET) chk("data_oe_setup", ps2_data_oe, (ph >= INH));
      else if (ph == INH + SET) chk("data_oe_start", ps2_data_oe, 1'b1);
      if (exp_done) begin
        m_active = 1'b0;
        m_done = -1;
      end
    end
  end

  // driver: raise tx_valid for one cycle; model decides whether it was taken
  task automatic req(input logic [7:0] b, output bit acc);
    tx_valid = 1'b1;
    tx_data = b;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    acc = !m_active;
    if (acc) begin
      m_active = 1'b1;
      m_acc = cyc;
      m_done = -1;
    end
  endtask

  // device: waits for request-to-send, then clocks last_edge edges
  task automatic dev_run(input int last_edge, input bit ack_low, input int rst_edge,
                         output logic [10:0] frame, output int rel_cyc, output int fall_cyc);
    int t;
    bit stop;
    t = 0;
    stop = 1'b0;
    frame = '1;
    rel_cyc = cyc;
    fall_cyc = cyc;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && t < 200) begin
      @(negedge sys_clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL dev_request: got clk=%b data=%b after 200 cycles, required clk released with data low",
               ps2_clk_line, ps2_data_line);
      return;
    end
    frame[0] = ps2_data_line;
    for (int e = 1; e <= last_edge && !stop; e++) begin
      if (e == 11 && ack_low) dev_data_low = 1'b1;
      repeat (HALF) @(negedge sys_clk);
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      if (e == rst_edge) begin
        repeat (5) @(negedge sys_clk);
        sync_rst_n = 1'b0;
        @(negedge sys_clk);
        sync_rst_n = 1'b1;
        model_reset();
        repeat (HALF - 6) @(negedge sys_clk);
        dev_clk_low = 1'b0;
        stop = 1'b1;
      end else begin
        repeat (HALF) @(negedge sys_clk);
        if (e <= 10) frame[e] = ps2_data_line;
        dev_clk_low = 1'b0;
        if (e == 11) dev_data_low = 1'b0;
      end
      rel_cyc = cyc;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (m_active && n < budget) begin
      @(negedge sys_clk);
      #2;
      n++;
    end
    checks++;
    if (m_active) begin
      errors++;
      $display("FAIL done_wait: got transfer still open after %0d cycles, required completion", budget);
      m_active = 1'b0;
      m_done = -1;
    end
  endtask

  // full transfer; bus released 3 cycles before completion is the 2-flop sync plus the registered outputs
  task automatic run_xfer(input logic [7:0] b, input bit ack_low);
    bit acc;
    logic [10:0] fr;
    int rel, fal;
    req(b, acc);
    m_status_next = ack_low ? 2'b00 : 2'b01;
    dev_run(11, ack_low, 0, fr, rel, fal);
    chk("frame", fr, exp_frame(b));
    m_done = rel + 3;
    wait_done(3000);
    chk("status_after_done", tx_status, ack_low ? 2'b00 : 2'b01);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL global_timeout: got no finish, required end of test");
    $fatal(1, "global timeout");
  end

  initial begin : main
    bit acc, acc2, ak;
    logic [10:0] fr;
    int rel, fal;
    logic [7:0] b;

    chk("model_frame_ed", exp_frame(8'hED), 11'h7DA);
    chk("model_frame_00", exp_frame(8'h00), 11'h600);
    chk("model_frame_55", exp_frame(8'h55), 11'h6AA);
    chk("model_frame_ff", exp_frame(8'hFF), 11'h7FE);

    repeat (2) @(negedge sys_clk);
    chk_en = 1'b1;
    chk("reset_tx_ready", tx_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_status", tx_status, 2'b00);
    chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    @(negedge sys_clk);
    sync_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // 0xED, ACK
    run_xfer(8'hED, 1'b1);
    chk("status_ed_ack", tx_status, 2'b00);

    // 0x00, NACK
    run_xfer(8'h00, 1'b0);
    chk("status_00_nack", tx_status, 2'b01);

    // 0x55, device silent: timeout 2000 cycles after START entry
    req(8'h55, acc);
    m_status_next = 2'b10;
    m_done = m_acc + INH + SET + TO;
    wait_done(3000);
    chk("status_timeout", tx_status, 2'b10);
    chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // second request while busy is dropped; back-to-back send after done
    @(negedge sys_clk);
    req(8'h12, acc);
    repeat (5) @(negedge sys_clk);
    req(8'hAA, acc2);
    m_status_next = 2'b00;
    dev_run(11, 1'b1, 0, fr, rel, fal);
    chk("frame_busy_ignored", fr, exp_frame(8'h12));
    m_done = rel + 3;
    wait_done(3000);
    run_xfer(8'hF4, 1'b1);

    // reset after 5th falling edge, then a clean 0xFF
    @(negedge sys_clk);
    req(8'hC3, acc);
    dev_run(11, 1'b1, 5, fr, rel, fal);
    chk("post_reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("post_reset_ready", tx_ready, 1'b1);
    repeat (40) @(negedge sys_clk);
    run_xfer(8'hFF, 1'b1);
    chk("status_ff_ack", tx_status, 2'b00);

    // device stalls after edge 6
    @(negedge sys_clk);
    req(8'h3A, acc);
    m_status_next = 2'b10;
    dev_run(6, 1'b0, 0, fr, rel, fal);
    chk("frame_partial", fr[6:0], exp_frame(8'h3A) & 11'h07F);
    m_done = fal + 3 + TO;
    wait_done(3000);
    chk("status_stall", tx_status, 2'b10);

    // randomized bytes with random ACK/NACK
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      ak = 1'($urandom_range(0, 1));
      run_xfer(b, ak);
    end

    repeat (5) @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
